// File: rtl/axi_protocol_monitor.sv
// rtl/axi_protocol_monitor.sv - passive AXI link monitor with sticky protocol error flags
// Tracks write/read bursts in small {id,len} FIFOs; checks stability, xLAST, response order/ID, overflow.
module axi_protocol_monitor #(
  parameter int AWIDTH          = 32,
  parameter int IDWIDTH         = 4,
  parameter int LENWIDTH        = 8,
  parameter int MAX_OUTSTANDING = 4,
  parameter int CW              = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                i_aclk,
  input  logic                i_rst,
  input  logic                i_clear,
  input  logic                i_awvalid,
  input  logic                i_awready,
  input  logic [IDWIDTH-1:0]  i_awid,
  input  logic [AWIDTH-1:0]   i_awaddr,
  input  logic [LENWIDTH-1:0] i_awlen,
  input  logic [1:0]          i_awburst,
  input  logic                i_wvalid,
  input  logic                i_wready,
  input  logic                i_wlast,
  input  logic                i_bvalid,
  input  logic                i_bready,
  input  logic [IDWIDTH-1:0]  i_bid,
  input  logic                i_arvalid,
  input  logic                i_arready,
  input  logic [IDWIDTH-1:0]  i_arid,
  input  logic [AWIDTH-1:0]   i_araddr,
  input  logic [LENWIDTH-1:0] i_arlen,
  input  logic [1:0]          i_arburst,
  input  logic                i_rvalid,
  input  logic                i_rready,
  input  logic                i_rlast,
  input  logic [IDWIDTH-1:0]  i_rid,
  output logic [14:0]         o_err,
  output logic                o_err_any,
  output logic [CW-1:0]       o_wr_outstanding,
  output logic [CW-1:0]       o_rd_outstanding
);
  localparam int PW   = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int EW   = IDWIDTH + LENWIDTH;
  localparam int AXW  = IDWIDTH + AWIDTH + LENWIDTH + 2;
  localparam int SW   = 2 * IDWIDTH + 2;
  localparam int BW   = LENWIDTH + 1;
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(MAX_OUTSTANDING);
  localparam logic [PW-1:0] PTR_ONE  = PW'(1);
  localparam logic [PW-1:0] PTR_LAST = PW'(MAX_OUTSTANDING - 1);
  localparam logic [BW-1:0] BEAT_ONE = BW'(1);

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    ptr_inc = (p == PTR_LAST) ? '0 : p + PTR_ONE;
  endfunction

  logic aw_xfer, w_xfer, b_xfer, ar_xfer, r_xfer;
  logic [AXW-1:0] aw_pay, ar_pay, aw_pay_q, aw_pay_d, ar_pay_q, ar_pay_d;
  logic [SW-1:0]  sm_pay, sm_pay_q, sm_pay_d;
  logic [4:0]     vld, rdy, vld_q, vld_d, rdy_q, rdy_d, chg, unstable;

  logic [EW-1:0] wr_mem_q [MAX_OUTSTANDING];
  logic [EW-1:0] wr_mem_d [MAX_OUTSTANDING];
  logic [EW-1:0] rd_mem_q [MAX_OUTSTANDING];
  logic [EW-1:0] rd_mem_d [MAX_OUTSTANDING];
  logic [PW-1:0] wptr_q, wptr_d, wptr_w_q, wptr_w_d, bptr_q, bptr_d;
  logic [PW-1:0] rwptr_q, rwptr_d, rptr_q, rptr_d;
  logic [CW-1:0] wr_cnt_q, wr_cnt_d, wdone_q, wdone_d, rd_cnt_q, rd_cnt_d;
  logic [BW-1:0] wbeat_q, wbeat_d, rbeat_q, rbeat_d;
  logic [14:0]   err_q, err_d, err_set;

  logic          wr_full, w_have, b_pop, aw_push, w_beat, w_exp_last, w_done;
  logic          rd_full, r_have, r_beat, r_exp_last, r_done, ar_push;
  logic [EW-1:0] w_entry, r_entry, b_entry;

  assign aw_xfer = i_awvalid & i_awready;
  assign w_xfer  = i_wvalid & i_wready;
  assign b_xfer  = i_bvalid & i_bready;
  assign ar_xfer = i_arvalid & i_arready;
  assign r_xfer  = i_rvalid & i_rready;

  // Channel order AW, W, AR, B, R matches error indices 0..4.
  assign aw_pay = {i_awid, i_awaddr, i_awlen, i_awburst};
  assign ar_pay = {i_arid, i_araddr, i_arlen, i_arburst};
  assign sm_pay = {i_rid, i_rlast, i_bid, i_wlast};
  assign vld    = {i_rvalid, i_bvalid, i_arvalid, i_wvalid, i_awvalid};
  assign rdy    = {i_rready, i_bready, i_arready, i_wready, i_awready};
  assign chg    = {sm_pay[SW-1:IDWIDTH+1] != sm_pay_q[SW-1:IDWIDTH+1],
                   sm_pay[IDWIDTH:1] != sm_pay_q[IDWIDTH:1],
                   ar_pay != ar_pay_q,
                   sm_pay[0] != sm_pay_q[0],
                   aw_pay != aw_pay_q};
  assign unstable = vld_q & ~rdy_q & (~vld | chg);

  // Write side: entries between bptr and wptr_w already finished their W beats (wdone of them).
  assign wr_full    = (wr_cnt_q == CNT_MAX);
  assign w_have     = (wr_cnt_q != wdone_q);
  assign b_pop      = b_xfer & (wdone_q != '0);
  assign aw_push    = aw_xfer & (~wr_full | b_pop);
  assign w_entry    = w_have ? wr_mem_q[wptr_w_q] : {i_awid, i_awlen};
  assign w_beat     = w_xfer & (w_have | aw_push);
  assign w_exp_last = (wbeat_q == {1'b0, w_entry[LENWIDTH-1:0]});
  assign w_done     = w_beat & (i_wlast | w_exp_last);
  assign b_entry    = wr_mem_q[bptr_q];

  // Read side: r_done never depends on ar_push, so the full-with-pop case has no loop.
  assign rd_full    = (rd_cnt_q == CNT_MAX);
  assign r_have     = (rd_cnt_q != '0);
  assign r_entry    = r_have ? rd_mem_q[rptr_q] : {i_arid, i_arlen};
  assign r_beat     = r_xfer & (r_have | ar_xfer);
  assign r_exp_last = (rbeat_q == {1'b0, r_entry[LENWIDTH-1:0]});
  assign r_done     = r_beat & (i_rlast | r_exp_last);
  assign ar_push    = ar_xfer & (~rd_full | r_done);

  always_comb begin
    err_set       = '0;
    err_set[4:0]  = unstable;
    err_set[5]    = w_beat & (i_wlast != w_exp_last);
    err_set[6]    = w_xfer & ~w_beat;
    err_set[7]    = b_xfer & (wdone_q == '0);
    err_set[8]    = b_pop & (i_bid != b_entry[EW-1:LENWIDTH]);
    err_set[9]    = r_beat & (i_rlast != r_exp_last);
    err_set[10]   = r_xfer & ~r_beat;
    err_set[11]   = r_beat & (i_rid != r_entry[EW-1:LENWIDTH]);
    err_set[12]   = aw_xfer & ~aw_push;
    err_set[13]   = ar_xfer & ~ar_push;
    err_set[14]   = (i_awvalid & (i_awburst == 2'b11)) | (i_arvalid & (i_arburst == 2'b11));
  end

  always_comb begin
    aw_pay_d = aw_pay;
    ar_pay_d = ar_pay;
    sm_pay_d = sm_pay;
    vld_d    = vld;
    rdy_d    = rdy;
    wr_mem_d = wr_mem_q;
    rd_mem_d = rd_mem_q;
    wptr_d   = wptr_q;
    wptr_w_d = wptr_w_q;
    bptr_d   = bptr_q;
    rwptr_d  = rwptr_q;
    rptr_d   = rptr_q;
    wr_cnt_d = wr_cnt_q;
    wdone_d  = wdone_q;
    rd_cnt_d = rd_cnt_q;
    wbeat_d  = wbeat_q;
    rbeat_d  = rbeat_q;
    err_d    = i_clear ? '0 : (err_q | err_set);

    if (aw_push) begin
      wr_mem_d[wptr_q] = {i_awid, i_awlen};
      wptr_d           = ptr_inc(wptr_q);
    end
    if (w_done) begin
      wptr_w_d = ptr_inc(wptr_w_q);
      wbeat_d  = '0;
    end else if (w_beat) begin
      wbeat_d = wbeat_q + BEAT_ONE;
    end
    if (b_pop) bptr_d = ptr_inc(bptr_q);
    if (aw_push && !b_pop) wr_cnt_d = wr_cnt_q + CNT_ONE;
    else if (!aw_push && b_pop) wr_cnt_d = wr_cnt_q - CNT_ONE;
    if (w_done && !b_pop) wdone_d = wdone_q + CNT_ONE;
    else if (!w_done && b_pop) wdone_d = wdone_q - CNT_ONE;

    if (ar_push) begin
      rd_mem_d[rwptr_q] = {i_arid, i_arlen};
      rwptr_d           = ptr_inc(rwptr_q);
    end
    if (r_done) begin
      rptr_d  = ptr_inc(rptr_q);
      rbeat_d = '0;
    end else if (r_beat) begin
      rbeat_d = rbeat_q + BEAT_ONE;
    end
    if (ar_push && !r_done) rd_cnt_d = rd_cnt_q + CNT_ONE;
    else if (!ar_push && r_done) rd_cnt_d = rd_cnt_q - CNT_ONE;
  end

  always_ff @(posedge i_aclk) begin
    if (i_rst) begin
      aw_pay_q <= '0;
      ar_pay_q <= '0;
      sm_pay_q <= '0;
      vld_q    <= '0;
      rdy_q    <= '0;
      wr_mem_q <= '{default: '0};
      rd_mem_q <= '{default: '0};
      wptr_q   <= '0;
      wptr_w_q <= '0;
      bptr_q   <= '0;
      rwptr_q  <= '0;
      rptr_q   <= '0;
      wr_cnt_q <= '0;
      wdone_q  <= '0;
      rd_cnt_q <= '0;
      wbeat_q  <= '0;
      rbeat_q  <= '0;
      err_q    <= '0;
    end else begin
      aw_pay_q <= aw_pay_d;
      ar_pay_q <= ar_pay_d;
      sm_pay_q <= sm_pay_d;
      vld_q    <= vld_d;
      rdy_q    <= rdy_d;
      wr_mem_q <= wr_mem_d;
      rd_mem_q <= rd_mem_d;
      wptr_q   <= wptr_d;
      wptr_w_q <= wptr_w_d;
      bptr_q   <= bptr_d;
      rwptr_q  <= rwptr_d;
      rptr_q   <= rptr_d;
      wr_cnt_q <= wr_cnt_d;
      wdone_q  <= wdone_d;
      rd_cnt_q <= rd_cnt_d;
      wbeat_q  <= wbeat_d;
      rbeat_q  <= rbeat_d;
      err_q    <= err_d;
    end
  end

  assign o_err            = err_q;
  assign o_err_any        = |err_q;
  assign o_wr_outstanding = wr_cnt_q;
  assign o_rd_outstanding = rd_cnt_q;

endmodule

// File: tb/tb_axi_protocol_monitor.sv
// tb/tb_axi_protocol_monitor.sv - directed and randomized checks of axi_protocol_monitor
// Random phase uses queue-based burst bookkeeping as the reference for flags and counts.
module tb_axi_protocol_monitor;
  localparam int AW   = 32;
  localparam int IW   = 4;
  localparam int LW   = 8;
  localparam int MAXO = 4;
  localparam int CW   = $clog2(MAXO + 1);

  logic          clk, rst, clr;
  logic          awvalid, awready, wvalid, wready, wlast, bvalid, bready;
  logic          arvalid, arready, rvalid, rready, rlast;
  logic [IW-1:0] awid, bid, arid, rid;
  logic [AW-1:0] awaddr, araddr;
  logic [LW-1:0] awlen, arlen;
  logic [1:0]    awburst, arburst;
  logic [14:0]   err;
  logic          err_any;
  logic [CW-1:0] wr_out, rd_out;

  int n_assert = 0;
  int n_fail   = 0;

  typedef struct {int id; int len;} ent_t;
  ent_t        wq[$];
  ent_t        rq[$];
  int          bq[$];
  int          wbeat, rbeat;
  logic [14:0] m_err;

  axi_protocol_monitor #(.AWIDTH(AW), .IDWIDTH(IW), .LENWIDTH(LW), .MAX_OUTSTANDING(MAXO)) dut (
    .i_aclk(clk), .i_rst(rst), .i_clear(clr),
    .i_awvalid(awvalid), .i_awready(awready), .i_awid(awid), .i_awaddr(awaddr),
    .i_awlen(awlen), .i_awburst(awburst),
    .i_wvalid(wvalid), .i_wready(wready), .i_wlast(wlast),
    .i_bvalid(bvalid), .i_bready(bready), .i_bid(bid),
    .i_arvalid(arvalid), .i_arready(arready), .i_arid(arid), .i_araddr(araddr),
    .i_arlen(arlen), .i_arburst(arburst),
    .i_rvalid(rvalid), .i_rready(rready), .i_rlast(rlast), .i_rid(rid),
    .o_err(err), .o_err_any(err_any),
    .o_wr_outstanding(wr_out), .o_rd_outstanding(rd_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    clr = 0; awvalid = 0; awready = 0; wvalid = 0; wready = 0; wlast = 0;
    bvalid = 0; bready = 0; arvalid = 0; arready = 0; rvalid = 0; rready = 0; rlast = 0;
  endtask

  task automatic drive_aw(input int id, input int len, input int burst);
    awvalid = 1; awready = 1; awid = IW'(id); awlen = LW'(len); awburst = 2'(burst);
    awaddr = $urandom;
  endtask

  task automatic drive_ar(input int id, input int len, input int burst);
    arvalid = 1; arready = 1; arid = IW'(id); arlen = LW'(len); arburst = 2'(burst);
    araddr = $urandom;
  endtask

  task automatic drive_w(input logic last);
    wvalid = 1; wready = 1; wlast = last;
  endtask

  task automatic drive_b(input int id);
    bvalid = 1; bready = 1; bid = IW'(id);
  endtask

  task automatic drive_r(input int id, input logic last);
    rvalid = 1; rready = 1; rid = IW'(id); rlast = last;
  endtask

  initial begin
    rst = 1; idle();
    awid = 0; awaddr = 0; awlen = 0; awburst = 1; bid = 0;
    arid = 0; araddr = 0; arlen = 0; arburst = 1; rid = 0;
    step(); step();
    rst = 0;
    check("reset_err", 32'(err), 32'h0);
    check("reset_any", 32'(err_any), 32'h0);
    check("reset_wr", 32'(wr_out), 32'h0);
    check("reset_rd", 32'(rd_out), 32'h0);

    // clean write burst
    drive_aw(3, 3, 1); step(); idle();
    check("wr_one", 32'(wr_out), 32'h1);
    for (int i = 0; i < 4; i++) begin drive_w(i == 3); step(); end
    idle();
    check("wr_after_w", 32'(wr_out), 32'h1);
    drive_b(3); step(); idle();
    check("clean_err", 32'(err), 32'h0);
    check("clean_wr", 32'(wr_out), 32'h0);

    // AW payload change while stalled
    awvalid = 1; awready = 0; awaddr = 32'h100; step();
    awaddr = 32'h104; step();
    check("aw_unstable", 32'(err), 32'h1);
    idle(); step(); step();
    check("aw_sticky", 32'(err), 32'h1);
    check("aw_any", 32'(err_any), 32'h1);
    clr = 1; step(); idle();
    check("clear", 32'(err), 32'h0);
    check("stall_wr", 32'(wr_out), 32'h0);

    // early rlast, then a clean single-beat read
    drive_ar(1, 1, 1); step(); idle();
    drive_r(1, 1); step(); idle();
    check("rlast_early", 32'(err), 32'h200);
    check("rlast_rd", 32'(rd_out), 32'h0);
    drive_ar(1, 0, 1); step(); idle();
    drive_r(1, 1); step(); idle();
    check("rlast_ok", 32'(err), 32'h200);
    clr = 1; step(); idle();

    // write overflow, then push accepted alongside a B while full
    for (int i = 0; i < 5; i++) begin drive_aw(i, 0, 1); step(); end
    idle();
    check("wr_ovf", 32'(err), 32'h1000);
    check("wr_ovf_cnt", 32'(wr_out), 32'h4);
    clr = 1; step(); idle();
    drive_w(1); step(); idle();
    drive_aw(7, 0, 1); drive_b(0); step(); idle();
    check("full_push_b_err", 32'(err), 32'h0);
    check("full_push_b_cnt", 32'(wr_out), 32'h4);
    for (int i = 0; i < 4; i++) begin drive_w(1); step(); end
    idle();
    drive_b(1); step(); drive_b(2); step(); drive_b(3); step(); drive_b(7); step(); idle();
    check("drain_err", 32'(err), 32'h0);
    check("drain_wr", 32'(wr_out), 32'h0);

    // B in the same cycle as wlast is unexpected; one cycle later it is fine
    drive_aw(2, 1, 1); step(); idle();
    drive_w(0); step();
    drive_w(1); drive_b(2); step(); idle();
    check("b_early", 32'(err), 32'h80);
    check("b_early_wr", 32'(wr_out), 32'h1);
    drive_b(2); step(); idle();
    check("b_late", 32'(err), 32'h80);
    check("b_late_wr", 32'(wr_out), 32'h0);
    clr = 1; step(); idle();

    // R ID mismatch, reserved burst, reset mid-burst
    drive_ar(2, 0, 1); step(); idle();
    drive_r(5, 1); step(); idle();
    check("r_id", 32'(err), 32'h800);
    drive_ar(0, 3, 3); drive_aw(1, 0, 1); step(); idle();
    check("burst_rsvd", 32'(err), 32'h4800);
    check("mid_rd", 32'(rd_out), 32'h1);
    drive_r(0, 0); step(); idle();
    check("mid_err", 32'(err), 32'h4800);
    rst = 1; step(); rst = 0;
    check("rst_err", 32'(err), 32'h0);
    check("rst_any", 32'(err_any), 32'h0);
    check("rst_wr", 32'(wr_out), 32'h0);
    check("rst_rd", 32'(rd_out), 32'h0);
    drive_ar(0, 0, 1); step(); idle();
    drive_r(0, 1); step(); idle();
    check("post_rst_beat", 32'(err), 32'h0);

    // randomized single-handshake traffic against the queue model
    m_err = '0; wbeat = 0; rbeat = 0;
    for (int k = 0; k < 400; k++) begin
      int   op, id, len, burst;
      logic exp_last, last;
      op = $urandom_range(0, 6);
      idle();
      case (op)
        0, 3: begin
          id = $urandom_range(0, 3);
          len = $urandom_range(0, 3);
          burst = ($urandom_range(0, 9) == 0) ? 3 : $urandom_range(0, 2);
          if (burst == 3) m_err[14] = 1;
          if (op == 0) begin
            drive_aw(id, len, burst);
            if (wq.size() + bq.size() == MAXO) m_err[12] = 1;
            else wq.push_back('{id, len});
          end else begin
            drive_ar(id, len, burst);
            if (rq.size() == MAXO) m_err[13] = 1;
            else rq.push_back('{id, len});
          end
        end
        1: begin
          if (wq.size() == 0) begin
            drive_w(1'($urandom)); m_err[6] = 1;
          end else begin
            exp_last = (wbeat == wq[0].len);
            last = ($urandom_range(0, 5) == 0) ? !exp_last : exp_last;
            drive_w(last);
            if (last != exp_last) m_err[5] = 1;
            if (last || exp_last) begin
              bq.push_back(wq[0].id); void'(wq.pop_front()); wbeat = 0;
            end else wbeat++;
          end
        end
        2: begin
          if (bq.size() == 0) begin
            drive_b($urandom_range(0, 3)); m_err[7] = 1;
          end else begin
            id = ($urandom_range(0, 4) == 0) ? $urandom_range(0, 3) : bq[0];
            drive_b(id);
            if (id != bq[0]) m_err[8] = 1;
            void'(bq.pop_front());
          end
        end
        4: begin
          if (rq.size() == 0) begin
            drive_r($urandom_range(0, 3), 1'($urandom)); m_err[10] = 1;
          end else begin
            exp_last = (rbeat == rq[0].len);
            last = ($urandom_range(0, 5) == 0) ? !exp_last : exp_last;
            id = ($urandom_range(0, 5) == 0) ? $urandom_range(0, 3) : rq[0].id;
            drive_r(id, last);
            if (id != rq[0].id) m_err[11] = 1;
            if (last != exp_last) m_err[9] = 1;
            if (last || exp_last) begin
              void'(rq.pop_front()); rbeat = 0;
            end else rbeat++;
          end
        end
        5: begin
          clr = 1; m_err = '0;
        end
        default: ;
      endcase
      step();
      check("rnd_err", 32'(err), 32'(m_err));
      check("rnd_wr", 32'(wr_out), 32'(wq.size() + bq.size()));
      check("rnd_rd", 32'(rd_out), 32'(rq.size()));
    end
    idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/axi_protocol_monitor.md
Name: axi_protocol_monitor

Overview:
Passive, synthesisable AXI protocol monitor. It is the sequential successor to the interface-level assertions, and it is parametrised in ID, address and length width and in outstanding depth. It taps one manager/subordinate link and tracks bursts through per-direction FIFOs. It checks handshake stability, burst length against xLAST, response ordering and ID, and overflow, then reports sticky error flags and outstanding counts.

Parameters:
AWIDTH, 32, address width
IDWIDTH, 4, ID width
LENWIDTH, 8, AxLEN width (beats = len+1)
MAX_OUTSTANDING, 4, tracked bursts per direction, >=1; power of two not required
CW, $clog2(MAX_OUTSTANDING+1), width of the count outputs (derived)

Ports:
i_aclk  in  1  clock; all logic on posedge
i_rst  in  1  synchronous, active-high reset
i_clear  in  1  clears sticky error flags only
i_awvalid, i_awready  in  1 each  AW handshake
i_awid / i_awaddr / i_awlen / i_awburst  in  IDWIDTH / AWIDTH / LENWIDTH / 2  AW payload
i_wvalid, i_wready, i_wlast  in  1 each  W handshake and last
i_bvalid, i_bready  in  1 each  B handshake
i_bid  in  IDWIDTH  B ID
i_arvalid, i_arready  in  1 each  AR handshake
i_arid / i_araddr / i_arlen / i_arburst  in  IDWIDTH / AWIDTH / LENWIDTH / 2  AR payload
i_rvalid, i_rready, i_rlast  in  1 each  R handshake and last
i_rid  in  IDWIDTH  R ID
o_err  out  15  sticky error flags (index list below)
o_err_any  out  1  OR of o_err, combinational
o_wr_outstanding  out  CW  AW accepted minus B accepted
o_rd_outstanding  out  CW  AR accepted minus final R beats accepted

Behaviour:
- Reset: o_err=0, both counts 0, FIFOs empty, beat counters 0, held-valid registers 0. The monitor never drives the bus.
- Handshake: xfer = valid & ready, sampled at posedge.
- Error indices: 0 AW_UNSTABLE, 1 W_UNSTABLE, 2 AR_UNSTABLE, 3 B_UNSTABLE, 4 R_UNSTABLE, 5 WLAST_MISMATCH, 6 W_NO_AW, 7 B_UNEXPECTED, 8 B_ID, 9 RLAST_MISMATCH, 10 R_UNEXPECTED, 11 R_ID, 12 WR_OVERFLOW, 13 RD_OVERFLOW, 14 BURST_RESERVED.
- Flag timing: a flag sets on the posedge after the offending cycle and stays set until i_clear or i_rst. i_clear has priority over a new set in the same cycle.
- Stability: register the previous cycle's valid, ready and payload.
  - If previous valid=1 and ready=0, then current valid=0 or a changed payload sets the channel's UNSTABLE flag.
  - Payload compared per channel: AW id/addr/len/burst; W wlast; AR id/addr/len/burst; B bid; R rid/rlast.
- BURST_RESERVED: awvalid with awburst==2'b11, or arvalid with arburst==2'b11.
- Write FIFO (MAX_OUTSTANDING entries of {awid, awlen}) has one write pointer and two read pointers, wptr_w (W progress) and bptr (B retire). Occupancy is measured against bptr.
  - AW xfer with FIFO full and no B xfer that cycle: set WR_OVERFLOW and drop the entry. Full plus B xfer in the same cycle: the push is accepted.
- W beat counter (LENWIDTH+1 bits) counts beats of the entry at wptr_w.
  - W xfer with no entry at wptr_w and no same-cycle AW xfer: set W_NO_AW and ignore the beat. A same-cycle AW bypasses into the counter logic.
  - Expected last beat is counter==awlen. If wlast is high early or low on the expected last beat, set WLAST_MISMATCH.
  - In all cases the burst completes on wlast or on the expected last beat, whichever comes first. Completion resets the counter, advances wptr_w and increments wdone.
- B path: a B xfer needs wdone>0 from prior cycles; a wlast completing in the same cycle does not count.
  - If wdone==0, set B_UNEXPECTED and change nothing else.
  - Otherwise compare bid to the id at bptr; a mismatch sets B_ID. Then pop bptr and decrement wdone.
- Read FIFO {arid, arlen} with an R beat counter. Responses are required in order, and the R beat counter follows the W rules.
  - R xfer with the FIFO empty and no same-cycle AR: set R_UNEXPECTED.
  - rid != head id on any beat: set R_ID.
  - rlast early or missing on the expected last beat: set RLAST_MISMATCH. Then pop and resync as for W.
  - Full without pop: set RD_OVERFLOW.
- Counts: a same-cycle increment and decrement leave the count unchanged. Counts saturate at 0 and at MAX_OUTSTANDING, and never wrap.

Test Plan:
- AW id=3 len=3, four W beats with wlast on beat 4, B id=3 -> o_err=0; o_wr_outstanding goes 1 then 0 the cycle after the B xfer.
- awvalid=1, awready=0, awaddr changes 0x100->0x104 while stalled -> o_err[0]=1 and stays 1 until i_clear, after which o_err=0.
- AR len=1, R beats with rlast on beat 1 -> o_err[9]=1; a following AR len=0 with rlast on beat 1 -> no new flag.
- Five AWs with MAX_OUTSTANDING=4 and no B -> o_err[12]=1, o_wr_outstanding=4; AW on the same cycle as a B while full -> no flag.
- B xfer on the same cycle as the wlast handshake -> o_err[7]=1; B one cycle later -> accepted with no further flag.
- AR id=2, then R with rid=5 -> o_err[11]=1; AR with arburst=2'b11 -> o_err[14]=1; i_rst mid-burst -> all outputs 0 on the next posedge.
